// File: rtl/lock_reg_pkg.sv
// lock_reg_pkg: shared FSM states, register indices and read-policy decision for lock_reg_reader.
package lock_reg_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    localparam logic [1:0] REG_IDX_1 = 2'd0;
    localparam logic [1:0] REG_IDX_2 = 2'd1;
    localparam logic [1:0] REG_IDX_3 = 2'd2;
    localparam logic [1:0] REG_IDX_4 = 2'd3;

    // Scan mode always wins over the debug unlock for a locked register.
    function automatic logic read_permitted(input logic [3:0] lock, input logic [1:0] idx,
                                            input logic dbg_unlocked, input logic scan);
        return !lock[idx] || (dbg_unlocked && !scan);
    endfunction

endpackage

// File: rtl/lock_audit_counter.sv
// lock_audit_counter: saturating count of denied reads; clear has priority over increment.
module lock_audit_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/lock_reg_reader.sv
// lock_reg_reader: policy-gated read port for four lockable registers.
// Define LOCK_READ_AUDIT_EN to count denied reads on denied_count (otherwise tied to 0).
import lock_reg_pkg::*;

module lock_reg_reader #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_addr,
    input  logic [DATA_W-1:0] reg_data_1,
    input  logic [DATA_W-1:0] reg_data_2,
    input  logic [DATA_W-1:0] reg_data_3,
    input  logic [DATA_W-1:0] reg_data_4,
    input  logic [3:0]        lock_status,
    input  logic              debug_unlocked,
    input  logic              scan_mode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              audit_clr,
    output logic [CNT_W-1:0]  denied_count
);

    state_t            state, state_nxt;
    logic [1:0]        addr_q;
    logic [DATA_W-1:0] data_q, sel_data;
    logic              err_q, permit;

    assign permit   = read_permitted(lock_status, addr_q, debug_unlocked, scan_mode);
    assign sel_data = addr_q == REG_IDX_1 ? reg_data_1 :
                      addr_q == REG_IDX_2 ? reg_data_2 :
                      addr_q == REG_IDX_3 ? reg_data_3 : reg_data_4;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req_valid ? CHECK : IDLE;
            CHECK:   state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // The response is captured once in CHECK so later lock/mode changes cannot alter it.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid)
                addr_q <= req_addr;
            if (state == CHECK) begin
                data_q <= permit ? sel_data : '0;
                err_q  <= !permit;
            end
        end
    end

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_data  = rsp_valid ? data_q : '0;
    assign rsp_err   = rsp_valid && err_q;

`ifdef LOCK_READ_AUDIT_EN
    lock_audit_counter #(.CNT_W(CNT_W)) u_audit (
        .Clk    (Clk),
        .resetn (resetn),
        .clr    (audit_clr),
        .inc    (state == CHECK && !permit),
        .count  (denied_count)
    );
`else
    logic unused_audit_clr;
    assign unused_audit_clr = audit_clr;
    assign denied_count     = '0;
`endif

endmodule

// File: tb/tb_lock_reg_reader.sv
// tb_lock_reg_reader: directed self-checking bench for lock_reg_reader.
module tb_lock_reg_reader;

`ifdef LOCK_READ_AUDIT_EN
    localparam int AUD = 1;
`else
    localparam int AUD = 0;
`endif

    logic        Clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_addr;
    logic [15:0] reg_data_1, reg_data_2, reg_data_3, reg_data_4, rsp_data;
    logic [3:0]  lock_status;
    logic        debug_unlocked, scan_mode, audit_clr;
    logic [7:0]  denied_count;
    int          passed = 0;
    int          total = 0;

    always #5 Clk = ~Clk;

    lock_reg_reader dut (
        .Clk(Clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .reg_data_1(reg_data_1), .reg_data_2(reg_data_2),
        .reg_data_3(reg_data_3), .reg_data_4(reg_data_4), .lock_status(lock_status),
        .debug_unlocked(debug_unlocked), .scan_mode(scan_mode), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .audit_clr(audit_clr), .denied_count(denied_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One read with rsp_ready held high: request in cycle N, response in cycle N+2.
    task automatic rd(input logic [1:0] a, input logic [15:0] ed, input logic ee, input string tag);
        req_addr  = a;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_check_ready"}, req_ready, 0);
        chk({tag, "_check_valid"}, rsp_valid, 0);
        tick();
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, ed);
        chk({tag, "_err"}, rsp_err, ee);
        tick();
        chk({tag, "_idle_ready"}, req_ready, 1);
        chk({tag, "_idle_valid"}, rsp_valid, 0);
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_addr = 2'd0; rsp_ready = 1'b1;
        reg_data_1 = 16'h1111; reg_data_2 = 16'hA5A5; reg_data_3 = 16'h5A5A; reg_data_4 = 16'hC3C3;
        lock_status = 4'b0000; debug_unlocked = 1'b0; scan_mode = 1'b0; audit_clr = 1'b0;
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_denied", denied_count, 0);
        @(negedge Clk);
        resetn = 1'b1;
        tick();

        rd(2'd1, 16'hA5A5, 1'b0, "unlocked");
        lock_status = 4'b0100;
        rd(2'd2, 16'h0000, 1'b1, "locked");
        chk("locked_denied", denied_count, AUD);
        debug_unlocked = 1'b1;
        rd(2'd2, 16'h5A5A, 1'b0, "debug_unlock");
        lock_status = 4'b1111; scan_mode = 1'b1;
        rd(2'd3, 16'h0000, 1'b1, "scan_deny");
        chk("scan_denied", denied_count, 2 * AUD);
        scan_mode = 1'b0;
        rd(2'd3, 16'hC3C3, 1'b0, "scan_off");

        lock_status = 4'b0000; rsp_ready = 1'b0;
        req_addr = 2'd0; req_valid = 1'b1;
        tick();
        tick();
        lock_status = 4'b1111; scan_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 16'h1111);
            chk("bp_err", rsp_err, 0);
            chk("bp_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("bp_release_ready", req_ready, 1);
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_data", rsp_data, 0);
        chk("bp_denied", denied_count, 2 * AUD);

        for (int i = 0; i < 300; i++) begin
            req_addr = 2'(i); req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            tick();
            tick();
        end
        chk("sat_count", denied_count, AUD ? 255 : 0);
        req_addr = 2'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; audit_clr = 1'b1;
        tick();
        audit_clr = 1'b0;
        chk("clr_priority_err", rsp_err, 1);
        chk("clr_priority_count", denied_count, 0);
        tick();
        rd(2'd1, 16'h0000, 1'b1, "post_clr");
        chk("post_clr_count", denied_count, AUD);

        scan_mode = 1'b0; lock_status = 4'b0000;
        req_addr = 2'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rst_check_state", req_ready, 0);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_ready", req_ready, 1);
        chk("async_rst_valid", rsp_valid, 0);
        @(negedge Clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_ready", req_ready, 1);
        end
        chk("post_rst_denied", denied_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lock_reg_reader.md
LOCK_REG_READER -- requirements
Module: lock_reg_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each protected register.
REQ-002 SHALL have parameter CNT_W, default 8: width of the denied-read counter.
REQ-003 SHALL have port Clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: read request present.
REQ-006 SHALL have port req_ready, output, 1: block can accept a request.
REQ-007 SHALL have port req_addr, input, 2: register index 0..3.
REQ-008 SHALL have port reg_data_1..reg_data_4, input, DATA_W each: current contents of the protected registers.
REQ-009 SHALL have port lock_status, input, 4: bit i set means register i+1 is locked.
REQ-010 SHALL have ports debug_unlocked, scan_mode, input, 1 each: privilege and mode qualifiers.
REQ-011 SHALL have port rsp_valid, output, 1: response present.
REQ-012 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-013 SHALL have port rsp_data, output, DATA_W: read data.
REQ-014 SHALL have port rsp_err, output, 1: read denied.
REQ-015 SHALL have port audit_clr, input, 1: synchronous clear of audit state.
REQ-016 SHALL have port denied_count, output, CNT_W: number of denied reads, saturating.

Function
REQ-017 SHALL implement an FSM with states IDLE, CHECK and RESP; req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge where IDLE and req_valid=1, register req_addr, and move to CHECK.
REQ-019 SHALL evaluate the access policy in CHECK using lock_status, debug_unlocked, scan_mode and reg_data_* present during the CHECK cycle, then move to RESP.
REQ-020 SHALL permit a read when the addressed lock bit is 0, or when debug_unlocked=1 and scan_mode=0.
REQ-021 SHALL deny a read of a locked register whenever scan_mode=1, regardless of debug_unlocked.
REQ-022 SHALL drive rsp_data equal to the addressed register and rsp_err=0 on a permitted read.
REQ-023 SHALL drive rsp_data=0 and rsp_err=1 on a denied read; locked data never appears on rsp_data.
REQ-024 SHALL assert rsp_valid in RESP, exactly 2 cycles after acceptance, and hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1.
REQ-025 SHALL return to IDLE on the edge where RESP and rsp_ready=1; the next request is accepted no earlier than the following edge.
REQ-026 SHALL keep rsp_data=0 and rsp_err=0 whenever rsp_valid=0.
REQ-027 SHALL ignore lock or mode changes during RESP; the held response is not re-evaluated.

Reset
REQ-028 SHALL, on resetn=0 and asynchronously, enter IDLE and force req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0 and denied_count=0.
REQ-029 SHALL discard any in-flight request when reset asserts mid-operation, and SHALL issue no response for it after reset release.

Configuration
REQ-030 SHALL, with LOCK_READ_AUDIT_EN defined, increment denied_count by 1 per denied read on CHECK->RESP, saturate at all-ones, and clear it on audit_clr.
REQ-031 SHALL give audit_clr priority over a simultaneous increment (result 0).
REQ-032 SHALL, without LOCK_READ_AUDIT_EN, tie denied_count to 0, ignore audit_clr, and leave all other behaviour unchanged.

Structure
REQ-033 SHALL place the FSM state enum, the register-index constants and the policy-decision function in shared package lock_reg_pkg.
REQ-034 SHALL isolate the saturating audit counter in sub-module lock_audit_counter, instantiated only under LOCK_READ_AUDIT_EN.

Verification
REQ-035 SHALL cover unlocked read: lock_status=0000, reg_data_2=16'hA5A5, req addr 1 -> rsp_valid 2 cycles later, rsp_data=16'hA5A5, rsp_err=0.
REQ-036 SHALL cover locked read: lock_status=0100, debug_unlocked=0, addr 2 -> rsp_data=0, rsp_err=1, denied_count=1.
REQ-037 SHALL cover scan override: lock_status=1111, debug_unlocked=1, scan_mode=1, addr 3 -> rsp_err=1, rsp_data=0; with scan_mode=0 -> data returned, rsp_err=0.
REQ-038 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout; rsp_ready=1 -> IDLE on that edge.
REQ-039 SHALL cover saturation: 300 denied reads -> denied_count=255; then audit_clr asserted on the same edge as a deny -> denied_count=0.
REQ-040 SHALL cover reset in CHECK: resetn pulsed low -> rsp_valid stays 0 and req_ready=1 immediately.
